// File: rtl/tcb_mem.sv
// tcb_mem: single-port TCB subordinate memory with a configurable response delay.
// Optional error checking (misaligned or out-of-range address) is enabled by
// defining TCB_MEM_ERR_EN; without it err is tied low and addresses wrap.
module tcb_mem #(
    parameter int ABW  = 32,
    parameter int DBW  = 32,
    parameter int SLW  = 8,
    parameter int DLY  = 1,
    parameter int SIZE = 4096,
    localparam int BEW = DBW/SLW,
    localparam int LW  = $clog2(BEW),
    localparam int SZW = ($clog2(LW+1) < 1) ? 1 : $clog2(LW+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    output logic           rdy,
    input  logic           wen,
    input  logic [ABW-1:0] adr,
    input  logic [SZW-1:0] siz,
    input  logic [BEW-1:0] ben,
    input  logic [DBW-1:0] wdt,
    output logic [DBW-1:0] rdt,
    output logic           err
);

    localparam int AW    = $clog2(SIZE);
    localparam int WORDS = SIZE/BEW;

    logic [DBW-1:0]   mem_q [WORDS];
    logic             trn;
    logic [AW-LW-1:0] idx;
    logic             err_c;
    logic [DBW-1:0]   rdt_d;
    logic             err_d;

    // No backpressure: ready whenever out of reset.
    assign rdy = ~rst;
    assign trn = vld & rdy;
    assign idx = adr[AW-1:LW];

`ifdef TCB_MEM_ERR_EN
    logic [ABW-1:0] aln_msk;
    logic           mis;
    logic           oor;

    // Offset bits below the transfer size must be zero.
    assign aln_msk = ~({ABW{1'b1}} << siz);
    assign mis     = |(adr & aln_msk);

    if (ABW > AW) begin : g_oor
        assign oor = |adr[ABW-1:AW];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    assign err_c = trn & (mis | oor);
`else
    // Size and upper address bits only matter to the error checker.
    logic unused_cfg;
    assign unused_cfg = ^{siz, adr};
    assign err_c      = 1'b0;
`endif

    // Byte-lane write on the transfer edge; memory is never reset.
    always_ff @(posedge clk) begin
        if (trn && wen && !err_c) begin
            for (int n = 0; n < BEW; n++) begin
                if (ben[n]) mem_q[idx][n*SLW +: SLW] <= wdt[n*SLW +: SLW];
            end
        end
    end

    // Response for the current cycle: enabled read lanes in place, everything else zero.
    always_comb begin
        rdt_d = '0;
        err_d = err_c;
        if (trn && !wen && !err_c) begin
            for (int n = 0; n < BEW; n++) begin
                if (ben[n]) rdt_d[n*SLW +: SLW] = mem_q[idx][n*SLW +: SLW];
            end
        end
    end

    if (DLY == 0) begin : g_comb
        // trn already excludes reset, so the combinational response is zero in reset.
        assign rdt = rdt_d;
        assign err = err_d;
    end else begin : g_pipe
        logic [DLY-1:0][DBW-1:0] rdt_q;
        logic [DLY-1:0]          err_q;

        // Response shift pipeline; reset drops every pending response.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdt_q <= '0;
                err_q <= '0;
            end else begin
                rdt_q[0] <= rdt_d;
                err_q[0] <= err_d;
                for (int i = 1; i < DLY; i++) begin
                    rdt_q[i] <= rdt_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end

        // Outputs read as zero for the whole time reset is held.
        assign rdt = rst ? '0 : rdt_q[DLY-1];
        assign err = rst ? 1'b0 : err_q[DLY-1];
    end

endmodule

// File: tb/tb_tcb_mem.sv
// tb_tcb_mem: three tcb_mem instances (DLY=0,1,2) share one stimulus stream and
// are checked against a byte-array reference model with a response history.
module tb_tcb_mem;

    localparam int SIZE = 4096;
    localparam int BEW  = 4;
    localparam int NC   = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vld, wen;
    logic [31:0] adr, wdt;
    logic [1:0]  siz;
    logic [3:0]  ben;
    logic [2:0]        rdy;
    logic [2:0]        err;
    logic [2:0][31:0]  rdt;

    tcb_mem #(.DLY(0)) u_d0 (.clk(clk), .rst(rst), .vld(vld), .rdy(rdy[0]), .wen(wen), .adr(adr),
                             .siz(siz), .ben(ben), .wdt(wdt), .rdt(rdt[0]), .err(err[0]));
    tcb_mem #(.DLY(1)) u_d1 (.clk(clk), .rst(rst), .vld(vld), .rdy(rdy[1]), .wen(wen), .adr(adr),
                             .siz(siz), .ben(ben), .wdt(wdt), .rdt(rdt[1]), .err(err[1]));
    tcb_mem #(.DLY(2)) u_d2 (.clk(clk), .rst(rst), .vld(vld), .rdy(rdy[2]), .wen(wen), .adr(adr),
                             .siz(siz), .ben(ben), .wdt(wdt), .rdt(rdt[2]), .err(err[2]));

    // Reference model: byte memory plus per-cycle response and reset history.
    logic [7:0]  mem_m [SIZE];
    logic [31:0] h_rdt [NC];
    logic        h_err [NC];
    logic        h_rst [NC];
    int t = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", tag, t, obs, exp);
        end
    endtask

    // One clock cycle: drive, update model, check all instances at negedge.
    task automatic cyc(input logic r, input logic v, input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic [3:0] b, input logic [31:0] d);
        logic        e;
        logic [31:0] rr;
        int          base;
        logic        ok;
        logic [31:0] x_rdt;
        logic        x_err;
        rst = r; vld = v; wen = w; adr = a; siz = s; ben = b; wdt = d;
        e  = 1'b0;
        rr = '0;
        if (!r && v) begin
`ifdef TCB_MEM_ERR_EN
            e = ((a % (32'd1 << s)) != 0) || (a >= SIZE);
`endif
            base = int'((a % SIZE) / BEW) * BEW;
            if (!e) begin
                for (int n = 0; n < BEW; n++) begin
                    if (b[n]) begin
                        if (w) mem_m[base+n] = d[n*8 +: 8];
                        else   rr[n*8 +: 8]  = mem_m[base+n];
                    end
                end
            end
        end
        h_rdt[t] = rr;
        h_err[t] = e;
        h_rst[t] = r;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            // A response survives only if reset was low from its transfer to its slot.
            ok = (t - k >= 0);
            for (int j = t - k; j <= t; j++) if (j >= 0 && h_rst[j]) ok = 1'b0;
            x_rdt = ok ? h_rdt[t-k] : 32'h0;
            x_err = ok ? h_err[t-k] : 1'b0;
            check($sformatf("rdy_d%0d", k), {31'h0, rdy[k]}, {31'h0, !r});
            check($sformatf("rdt_d%0d", k), rdt[k], x_rdt);
            check($sformatf("err_d%0d", k), {31'h0, err[k]}, {31'h0, x_err});
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; vld = 1'b0; wen = 1'b0; adr = '0; siz = '0; ben = '0; wdt = '0;
        @(posedge clk);
        #1;
        // Reset, with vld held high to show nothing is accepted.
        cyc(1, 0, 0, 0, 2, 4'hf, 0);
        cyc(1, 1, 1, 0, 2, 4'hf, 32'hdeadbeef);
        cyc(1, 0, 0, 0, 2, 4'hf, 0);
        // Fill the first 16 words so every later read hits known data.
        for (int i = 0; i < 16; i++) cyc(0, 1, 1, 32'(i*4), 2, 4'hf, $urandom);
        // Full write then read back.
        cyc(0, 1, 1, 32'h00, 2, 4'hf, 32'h01234567);
        cyc(0, 1, 0, 32'h00, 2, 4'hf, 0);
        // Single-lane merge: expect 0x0123CC67.
        cyc(0, 1, 1, 32'h00, 2, 4'b0010, 32'hAABBCCDD);
        cyc(0, 1, 0, 32'h00, 2, 4'hf, 0);
        // Misaligned word access (error when checking is on, wraps to word 4 otherwise).
        cyc(0, 1, 1, 32'h11, 2, 4'hf, 32'h01234567);
        cyc(0, 1, 0, 32'h11, 2, 4'hf, 0);
        // Back-to-back reads.
        cyc(0, 1, 0, 32'h00, 2, 4'hf, 0);
        cyc(0, 1, 0, 32'h04, 2, 4'hf, 0);
        cyc(0, 1, 0, 32'h08, 2, 4'hf, 0);
        // Partial-lane read, then an idle slot.
        cyc(0, 1, 0, 32'h04, 2, 4'b0101, 0);
        cyc(0, 0, 0, 32'h00, 2, 4'hf, 0);
        // Read immediately followed by reset: its response must vanish.
        cyc(0, 1, 0, 32'h00, 2, 4'hf, 0);
        cyc(1, 0, 0, 32'h00, 2, 4'hf, 0);
        cyc(1, 0, 0, 32'h00, 2, 4'hf, 0);
        cyc(0, 0, 0, 32'h00, 2, 4'hf, 0);
        // Data written before reset must still be there.
        cyc(0, 1, 0, 32'h00, 2, 4'hf, 0);
        cyc(0, 0, 0, 32'h00, 2, 4'hf, 0);
        cyc(0, 0, 0, 32'h00, 2, 4'hf, 0);
        // Random traffic including wrapping addresses, odd sizes and sparse resets.
        for (int i = 0; i < 600; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                a, 2'($urandom_range(0, 2)), 4'($urandom), $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tcb_mem.md
TCB_MEM -- requirements
Module: tcb_mem

Interface
REQ-001 Parameter ABW, default 32: address bus width in bits.
REQ-002 Parameter DBW, default 32: data bus width in bits, power of 2, at least SLW.
REQ-003 Parameter SLW, default 8: byte lane width; BEW = DBW/SLW lanes.
REQ-004 Parameter DLY, default 1: response delay in cycles after the transfer cycle, range 0..4.
REQ-005 Parameter SIZE, default 4096: memory capacity in bytes, power of 2, multiple of BEW.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port vld, input, 1 bit: request valid from the manager.
REQ-009 Port rdy, output, 1 bit: subordinate ready.
REQ-010 Port wen, input, 1 bit: 1 means write, 0 means read.
REQ-011 Port adr, input, ABW bits: byte address.
REQ-012 Port siz, input, clog2(clog2(BEW)+1) bits: log2 of the transfer size in bytes.
REQ-013 Port ben, input, BEW bits: byte enables; bit n selects lane n.
REQ-014 Port wdt, input, DBW bits: write data, little-endian lanes.
REQ-015 Port rdt, output, DBW bits: read data.
REQ-016 Port err, output, 1 bit: response error.

Function
REQ-017 A transfer occurs in a cycle where vld=1 and rdy=1 are both sampled at the rising clk edge.
REQ-018 rdy is 1 in every cycle with rst=0; the block never applies backpressure.
REQ-019 Word index = adr[clog2(SIZE)-1:clog2(BEW)]; higher address bits are ignored (address wraps modulo SIZE).
REQ-020 Write transfer: lanes with ben=1 are stored at the rising edge of the transfer cycle; lanes with ben=0 are unchanged.
REQ-021 Read transfer: each rdt lane with ben=1 returns the stored byte; each lane with ben=0 returns 0.
REQ-022 The read of a location in the cycle after a write to it returns the newly written data.
REQ-023 DLY=0: rdt and err are combinational and valid in the transfer cycle itself.
REQ-024 DLY=N>0: rdt and err are valid exactly N cycles after the transfer cycle, via an N-stage pipeline.
REQ-025 The pipeline accepts one transfer per cycle; back-to-back transfers produce back-to-back responses in order.
REQ-026 In response slots with no transfer, rdt=0 and err=0.
REQ-027 Write transfers respond with rdt=0.
REQ-028 Data is transferred on lanes in place; there is no rotation by address offset.

Reset
REQ-029 While rst=1: rdy=0, no transfer is accepted, all pipeline stages are cleared, rdt=0 and err=0.
REQ-030 Reset asserted mid-operation discards pending responses.
REQ-031 A write already committed at its transfer edge stays in memory when rst is asserted afterwards.
REQ-032 Memory contents are not initialized or cleared by reset.

Configuration
REQ-033 Macro TCB_MEM_ERR_EN enables error checking; this is the only compile-time option.
REQ-034 With TCB_MEM_ERR_EN defined, err=1 for a transfer whose adr is not a multiple of 2**siz, or whose adr is at or above SIZE.
REQ-035 With TCB_MEM_ERR_EN defined, an errored write changes no memory, and an errored read returns rdt=0.
REQ-036 Without TCB_MEM_ERR_EN, err is constant 0, misaligned addresses are accessed at their word index, and addresses wrap.

Verification
REQ-037 DLY=1: write adr=0x00, ben=1111, wdt=0x01234567, then read adr=0x00, ben=1111 -> rdt=0x01234567, err=0 one cycle after the read.
REQ-038 Write 0xAABBCCDD at 0x00 with ben=0010 over 0x01234567, then read ben=1111 -> rdt=0x0123CC67.
REQ-039 TCB_MEM_ERR_EN defined: write adr=0x11, siz=2, wdt=0x01234567 -> err=1, memory unchanged; read adr=0x11 -> err=1, rdt=0.
REQ-040 DLY=2: reads of 0x00, 0x04, 0x08 on three consecutive cycles -> three consecutive responses, in order, starting 2 cycles after the first read.
REQ-041 DLY=2: issue a read, then assert rst on the next cycle -> no response appears, rdt=0, err=0, rdy=0 during reset.
REQ-042 DLY=0: read in the same cycle as vld -> rdt is valid combinationally with err=0.
